// File: rtl/counter_updown_mod.sv
// Up/down modulo-MODULUS counter with enable, parallel load, synchronous clear,
// wrap/saturate selection, combinational terminal flag and registered rollover pulse.
module counter_updown_mod #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             terminal,
   output logic             rollover
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             rollover_q, rollover_d;
   logic             at_max, at_zero;

   assign at_max  = (count_q == MaxVal);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d    = count_q;
      rollover_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         // Out-of-range load values clamp to the top of the range.
         count_d = (load_value > MaxVal) ? MaxVal : load_value;
      end else if (enable) begin
         if (up_down) begin
            if (at_max) begin
               rollover_d = 1'b1;
               if (!SATURATE) count_d = '0;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               rollover_d = 1'b1;
               if (!SATURATE) count_d = MaxVal;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         rollover_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         rollover_q <= rollover_d;
      end
   end

   assign count    = count_q;
   assign rollover = rollover_q;
   // Same-cycle carry-out for cascading into the next stage's enable.
   assign terminal = enable & (up_down ? at_max : at_zero);

endmodule
